// File: rtl/axis_frame_checker_if.sv
// AXI-Stream bundle used on both sides of the frame checker.
// The master drives the payload and valid; the slave drives ready.
interface axis_frame_checker_if #(
   parameter int DATA_W = 512,
   parameter int KEEP_W = DATA_W / 8
);
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, tkeep, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_frame_checker.sv
// Downstream stage of the AXI-Stream bit reverser.
// Beats pass through a registered 2-entry skid slice. In parallel, each accepted
// beat is checked for tkeep framing and its bytes are accumulated. One status
// record is produced per frame, along with running frame and error counters.
module axis_frame_checker #(
   parameter int AXIS_DATA_WIDTH  = 512,
   parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
   parameter bit KEEP_MSB_ALIGNED = 1'b1,
   parameter int MAX_BYTES        = 9600,
   parameter int LEN_WIDTH        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   axis_frame_checker_if.slave  s_axis,
   axis_frame_checker_if.master m_axis,
   output logic                 stat_valid_o,
   output logic [LEN_WIDTH-1:0] stat_bytes_o,
   output logic                 stat_err_keep_o,
   output logic                 stat_err_oversize_o,
   output logic [31:0]          frame_cnt_o,
   output logic [31:0]          err_cnt_o
);
   localparam logic [LEN_WIDTH:0] MAX_L = (LEN_WIDTH+1)'(MAX_BYTES);

   logic [AXIS_DATA_WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
   logic [AXIS_KEEP_WIDTH-1:0] out_keep_q, out_keep_d, skid_keep_q, skid_keep_d;
   logic out_last_q, out_last_d, skid_last_q, skid_last_d;
   logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic tready_q, tready_d;

   logic s_accept, m_fire, out_load;

   logic [LEN_WIDTH-1:0] acc_q, acc_sum, beat_bytes;
   logic [LEN_WIDTH:0]   sum_full;
   logic                 sat, keep_bad, oversize, err_sticky_q;
   logic [AXIS_KEEP_WIDTH-1:0] run, run_inc;

   logic                 stat_valid_q, stat_err_keep_q, stat_err_oversize_q;
   logic [LEN_WIDTH-1:0] stat_bytes_q;
   logic [31:0]          frame_cnt_q, err_cnt_q;

   assign s_accept = s_axis.tvalid && tready_q;
   assign m_fire   = out_valid_q && m_axis.tready;
   assign out_load = !out_valid_q || m_fire;

   // Skid slice next state: output reg refills from skid first, else from the input;
   // a beat accepted while the output is stalled parks in the skid reg.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_keep_d   = out_keep_q;
      out_last_d   = out_last_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_keep_d  = skid_keep_q;
      skid_last_d  = skid_last_q;
      if (out_load) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_keep_d   = skid_keep_q;
            out_last_d   = skid_last_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = s_accept;
            if (s_accept) begin
               out_data_d = s_axis.tdata;
               out_keep_d = s_axis.tkeep;
               out_last_d = s_axis.tlast;
            end
         end
      end else if (s_accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = s_axis.tdata;
         skid_keep_d  = s_axis.tkeep;
         skid_last_d  = s_axis.tlast;
      end
      // ready is registered and depends only on skid occupancy, never on m_axis.tready
      tready_d = !skid_valid_d;
   end

   // Skid slice registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_keep_q   <= '0;
         out_last_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_keep_q  <= '0;
         skid_last_q  <= 1'b0;
         tready_q     <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_keep_q   <= out_keep_d;
         out_last_q   <= out_last_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_keep_q  <= skid_keep_d;
         skid_last_q  <= skid_last_d;
         tready_q     <= tready_d;
      end
   end

   // Per-beat byte count, saturating accumulate and tkeep framing check.
   // run is of the form 0..01..1 exactly when the keep bits are contiguous from the aligned end.
   always_comb begin
      beat_bytes = '0;
      for (int i = 0; i < AXIS_KEEP_WIDTH; i++)
         beat_bytes = beat_bytes + LEN_WIDTH'(s_axis.tkeep[i]);
      sum_full = {1'b0, acc_q} + {1'b0, beat_bytes};
      sat      = sum_full[LEN_WIDTH];
      acc_sum  = sat ? '1 : sum_full[LEN_WIDTH-1:0];
      oversize = sat || ({1'b0, acc_sum} > MAX_L);
      run      = KEEP_MSB_ALIGNED ? ~s_axis.tkeep : s_axis.tkeep;
      run_inc  = run + AXIS_KEEP_WIDTH'(1);
      if (s_axis.tlast)
         keep_bad = (s_axis.tkeep == '0) || ((run & run_inc) != '0);
      else
         keep_bad = (s_axis.tkeep != '1);
   end

   // Frame accounting: accumulate on every accepted beat, publish and clear on tlast.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q               <= '0;
         err_sticky_q        <= 1'b0;
         stat_valid_q        <= 1'b0;
         stat_bytes_q        <= '0;
         stat_err_keep_q     <= 1'b0;
         stat_err_oversize_q <= 1'b0;
         frame_cnt_q         <= '0;
         err_cnt_q           <= '0;
      end else begin
         stat_valid_q <= 1'b0;
         if (s_accept) begin
            if (s_axis.tlast) begin
               stat_valid_q        <= 1'b1;
               stat_bytes_q        <= acc_sum;
               stat_err_keep_q     <= err_sticky_q || keep_bad;
               stat_err_oversize_q <= oversize;
               frame_cnt_q         <= frame_cnt_q + 32'd1;
               if (err_sticky_q || keep_bad || oversize)
                  err_cnt_q <= err_cnt_q + 32'd1;
               acc_q        <= '0;
               err_sticky_q <= 1'b0;
            end else begin
               acc_q        <= acc_sum;
               err_sticky_q <= err_sticky_q || keep_bad;
            end
         end
      end
   end

   assign s_axis.tready       = tready_q;
   assign m_axis.tvalid       = out_valid_q;
   assign m_axis.tdata        = out_data_q;
   assign m_axis.tkeep        = out_keep_q;
   assign m_axis.tlast        = out_last_q;
   assign stat_valid_o        = stat_valid_q;
   assign stat_bytes_o        = stat_bytes_q;
   assign stat_err_keep_o     = stat_err_keep_q;
   assign stat_err_oversize_o = stat_err_oversize_q;
   assign frame_cnt_o         = frame_cnt_q;
   assign err_cnt_o           = err_cnt_q;
endmodule
